// File: rtl/reset_sequencer.sv
// Lock-qualified staged release of CHANNELS active-low resets with a saturating lock-loss counter.
// Build option: define RESET_SEQ_WATCHDOG_EN to add the HOLD watchdog that pulses pll_rst.
module reset_sequencer #(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned STAGE_DELAY     = 16,
   parameter int unsigned LOCK_FILTER     = 8,
   parameter int unsigned WATCHDOG_CYCLES = 100000
) (
   input  logic                clock,
   input  logic                rst,
   input  logic                pll_lock,
   input  logic                sw_reset_req,
   output logic [CHANNELS-1:0] resetn,
   output logic                ready,
   output logic [7:0]          lock_loss_count,
   output logic                pll_rst
);
   localparam int unsigned FILT_W  = $clog2(LOCK_FILTER) + 1;
   localparam int unsigned DELAY_W = $clog2(STAGE_DELAY) + 1;
   localparam int unsigned IDX_W   = $clog2(CHANNELS) + 1;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } state_t;

   state_t             state;
   logic               lock_meta;
   logic               lock_sync;
   logic [FILT_W-1:0]  filt_cnt;
   logic [DELAY_W-1:0] delay_cnt;
   logic [IDX_W-1:0]   idx;
   logic               abort_c;

   // Two-flop synchroniser for the asynchronous MMCM lock.
   always_ff @(posedge clock) begin
      if (rst) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_sync <= lock_meta;
      end
   end

   assign abort_c = (state != HOLD) && (!lock_sync || sw_reset_req);

   always_ff @(posedge clock) begin
      if (rst) begin
         state           <= HOLD;
         filt_cnt        <= '0;
         delay_cnt       <= '0;
         idx             <= '0;
         resetn          <= '0;
         ready           <= 1'b0;
         lock_loss_count <= '0;
      end else if (abort_c) begin
         // Coincident software request and lock loss still count as one lock loss.
         state     <= HOLD;
         filt_cnt  <= '0;
         delay_cnt <= '0;
         idx       <= '0;
         resetn    <= '0;
         ready     <= 1'b0;
         if (!lock_sync && (lock_loss_count != 8'hFF)) begin
            lock_loss_count <= lock_loss_count + 8'd1;
         end
      end else begin
         case (state)
            HOLD: begin
               resetn <= '0;
               ready  <= 1'b0;
               if (!lock_sync || sw_reset_req) begin
                  filt_cnt <= '0;
               end else if (filt_cnt == FILT_W'(LOCK_FILTER - 1)) begin
                  state     <= RELEASE;
                  filt_cnt  <= '0;
                  delay_cnt <= '0;
                  idx       <= '0;
               end else begin
                  filt_cnt <= filt_cnt + FILT_W'(1);
               end
            end
            RELEASE: begin
               if (delay_cnt == DELAY_W'(STAGE_DELAY - 1)) begin
                  delay_cnt <= '0;
                  resetn    <= resetn | (CHANNELS'(1) << idx);
                  idx       <= idx + IDX_W'(1);
                  if (idx == IDX_W'(CHANNELS - 1)) begin
                     state <= RUN;
                     ready <= 1'b1;
                  end
               end else begin
                  delay_cnt <= delay_cnt + DELAY_W'(1);
               end
            end
            RUN: begin
               resetn <= '1;
               ready  <= 1'b1;
            end
            default: begin
               state <= HOLD;
            end
         endcase
      end
   end

`ifdef RESET_SEQ_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES) + 1;

   logic [WD_W-1:0] hold_timer;
   logic [WD_W-1:0] timer_nxt_c;
   logic [2:0]      pulse_cnt;
   logic            wd_fire_c;

   // Fire on the cycle the HOLD timer reaches its last value; the timer then wraps to 0.
   assign timer_nxt_c = (hold_timer == WD_W'(WATCHDOG_CYCLES - 1)) ? '0 : hold_timer + WD_W'(1);
   assign wd_fire_c   = (state == HOLD) && !sw_reset_req &&
                        (timer_nxt_c == WD_W'(WATCHDOG_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (rst) begin
         hold_timer <= '0;
         pulse_cnt  <= '0;
         pll_rst    <= 1'b0;
      end else begin
         if ((state != HOLD) || sw_reset_req) begin
            hold_timer <= '0;
         end else begin
            hold_timer <= timer_nxt_c;
         end
         if (wd_fire_c) begin
            pulse_cnt <= 3'd3;
            pll_rst   <= 1'b1;
         end else if (pulse_cnt != 3'd0) begin
            pulse_cnt <= pulse_cnt - 3'd1;
            pll_rst   <= 1'b1;
         end else begin
            pll_rst <= 1'b0;
         end
      end
   end
`else
   // Watchdog not built: pll_rst is tied low whatever WATCHDOG_CYCLES is set to.
   assign pll_rst = 1'b0 && (WATCHDOG_CYCLES != 0);
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes, a monitor checks them.
module tb_reset_sequencer;
   localparam int unsigned CH = 4;
`ifdef RESET_SEQ_WATCHDOG_EN
   localparam int unsigned WD = 50;
`else
   localparam int unsigned WD = 100000;
`endif

   logic          clock = 1'b0;
   logic          rst;
   logic          pll_lock;
   logic          sw_reset_req;
   logic [CH-1:0] resetn;
   logic          ready;
   logic [7:0]    lock_loss_count;
   logic          pll_rst;

   typedef struct {
      int unsigned   at;
      logic [CH-1:0] rn;
      logic          rdy;
      logic [7:0]    cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   logic        mon_en = 1'b0;
   logic        pll_rst_seen = 1'b0;

   reset_sequencer #(
      .CHANNELS       (CH),
      .STAGE_DELAY    (16),
      .LOCK_FILTER    (8),
      .WATCHDOG_CYCLES(WD)
   ) dut (
      .clock          (clock),
      .rst            (rst),
      .pll_lock       (pll_lock),
      .sw_reset_req   (sw_reset_req),
      .resetn         (resetn),
      .ready          (ready),
      .lock_loss_count(lock_loss_count),
      .pll_rst        (pll_rst)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every change of the sequenced outputs must match the head of the queue.
   logic [CH-1:0] prev_rn;
   logic          prev_rdy;
   logic [7:0]    prev_cnt;
   always @(negedge clock) begin
      exp_t e;
      if (mon_en && (resetn !== prev_rn || ready !== prev_rdy || lock_loss_count !== prev_cnt)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change: actual resetn=%b ready=%b count=%0d required no change (cycle %0d)",
                     resetn, ready, lock_loss_count, cyc);
         end else begin
            e = exp_q.pop_front();
            check("event_cycle", 32'(cyc), 32'(e.at));
            check("resetn", 32'(resetn), 32'(e.rn));
            check("ready", 32'(ready), 32'(e.rdy));
            check("lock_loss_count", 32'(lock_loss_count), 32'(e.cnt));
         end
      end
      prev_rn  = resetn;
      prev_rdy = ready;
      prev_cnt = lock_loss_count;
   end

   always @(negedge clock) if (pll_rst === 1'b1) pll_rst_seen <= 1'b1;

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push(input int unsigned at, input logic [CH-1:0] rn, input logic rdy, input logic [7:0] cnt);
      exp_t e;
      e.at  = at;
      e.rn  = rn;
      e.rdy = rdy;
      e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   // Four releases spaced 16 cycles, first one at cycle 'first'.
   task automatic push_seq(input int unsigned first, input logic [7:0] cnt);
      push(first,      4'b0001, 1'b0, cnt);
      push(first + 16, 4'b0011, 1'b0, cnt);
      push(first + 32, 4'b0111, 1'b0, cnt);
      push(first + 48, 4'b1111, 1'b1, cnt);
   endtask

   task automatic wait_drain(input int unsigned bound, input string name);
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(negedge clock);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: actual %0d events pending required 0 (cycle %0d)", name, exp_q.size(), cyc);
         exp_q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: actual cycle %0d required finish", cyc);
      $fatal(1, "bench did not finish");
   end

   initial begin
      int unsigned t;
      int unsigned tl;
      int unsigned k;
      logic        wd_exp;
      logic [7:0]  exp_cnt;

      rst          = 1'b1;
      pll_lock     = 1'b0;
      sw_reset_req = 1'b0;
      tick(5);
      check("reset_resetn", 32'(resetn), 32'd0);
      check("reset_ready", 32'(ready), 32'd0);
      check("reset_count", 32'(lock_loss_count), 32'd0);
      check("reset_pll_rst", 32'(pll_rst), 32'd0);

      // HOLD with lock low: watchdog pulses (if built) at 49..52, 99..102 after reset release.
      rst    = 1'b0;
      mon_en = 1'b1;
      t      = cyc;
      for (int i = 0; i < 110; i++) begin
         tick(1);
         k = cyc - t;
`ifdef RESET_SEQ_WATCHDOG_EN
         wd_exp = (k >= 49) && (((k - 49) % 50) < 4);
`else
         wd_exp = 1'b0;
`endif
         check("pll_rst_hold", 32'(pll_rst), 32'(wd_exp));
      end

      // Cold start: resetn[0] at 26 cycles after the first high sample.
      t        = cyc;
      pll_lock = 1'b1;
      push_seq(t + 26, 8'd0);
      wait_drain(100, "cold_start");
      tick(5);

      // Lock loss in RUN: abort 3 cycles after the drop, replay 24 cycles after the abort.
      exp_cnt  = 8'd1;
      t        = cyc;
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      push(t + 3, 4'b0000, 1'b0, exp_cnt);
      push_seq(t + 27, exp_cnt);
      wait_drain(100, "lock_loss_run");
      tick(5);

      // Software abort from RUN, then again mid-RELEASE while resetn = 0011.
      t            = cyc;
      sw_reset_req = 1'b1;
      tick(1);
      sw_reset_req = 1'b0;
      push(t + 1,  4'b0000, 1'b0, exp_cnt);
      push(t + 25, 4'b0001, 1'b0, exp_cnt);
      push(t + 41, 4'b0011, 1'b0, exp_cnt);
      wait_drain(60, "sw_abort_run");
      tick(3);
      check("mid_release_resetn", 32'(resetn), 32'h3);
      t            = cyc;
      sw_reset_req = 1'b1;
      tick(1);
      sw_reset_req = 1'b0;
      push(t + 1, 4'b0000, 1'b0, exp_cnt);
      push_seq(t + 25, exp_cnt);
      wait_drain(100, "sw_abort_release");
      tick(5);

      // Drop lock and stay in HOLD, then a 5-high/1-low glitch before the final rise.
      exp_cnt  = 8'd2;
      t        = cyc;
      pll_lock = 1'b0;
      push(t + 3, 4'b0000, 1'b0, exp_cnt);
      wait_drain(10, "drop_for_glitch");
      tick(4);
      pll_lock = 1'b1;
      tick(5);
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      t        = cyc;
      push_seq(t + 26, exp_cnt);
      wait_drain(100, "glitch");
      tick(5);

      // Software request in HOLD restarts the lock qualification.
      exp_cnt  = 8'd3;
      t        = cyc;
      pll_lock = 1'b0;
      push(t + 3, 4'b0000, 1'b0, exp_cnt);
      wait_drain(10, "drop_for_hold_req");
      tick(4);
      t        = cyc;
      pll_lock = 1'b1;
      tick(6);
      sw_reset_req = 1'b1;
      tick(1);
      sw_reset_req = 1'b0;
      push_seq(t + 31, exp_cnt);
      wait_drain(100, "hold_sw_req");
      tick(5);

      // 260 lock losses; the counter saturates at 255.
      tl = cyc;
      for (int i = 0; i < 260; i++) begin
         tl       = cyc;
         pll_lock = 1'b0;
         tick(1);
         pll_lock = 1'b1;
         if (exp_cnt != 8'hFF) begin
            exp_cnt = exp_cnt + 8'd1;
            push(tl + 3, 4'b0000, 1'b0, exp_cnt);
         end
         tick(14);
      end
      push_seq(tl + 27, 8'hFF);
      wait_drain(100, "saturation");
      check("sat_count", 32'(lock_loss_count), 32'd255);
      tick(5);

      // Reset mid-run clears everything, then sequencing restarts like a cold start.
      mon_en = 1'b0;
      rst    = 1'b1;
      tick(3);
      check("rerst_resetn", 32'(resetn), 32'd0);
      check("rerst_ready", 32'(ready), 32'd0);
      check("rerst_count", 32'(lock_loss_count), 32'd0);
      check("rerst_pll_rst", 32'(pll_rst), 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;
      t      = cyc;
      push_seq(t + 26, 8'd0);
      wait_drain(100, "rerst_start");
      tick(10);

`ifndef RESET_SEQ_WATCHDOG_EN
      check("pll_rst_never_high", 32'(pll_rst_seen), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on and lock-loss reset controller that sits between the MMCM `LOCKED` output and the clocked fabric of a board top level. It synchronises and glitch-filters the PLL lock, then releases `CHANNELS` active-low resets one after another at a fixed stage spacing. It forces every channel back into reset on lock loss or on a software request. It also keeps a saturating lock-loss counter for debug readout.

## Interface
- `CHANNELS`, default 4: number of sequenced reset outputs, range 1..16.
- `STAGE_DELAY`, default 16: cycles between consecutive channel releases, range 1..65535.
- `LOCK_FILTER`, default 8: consecutive synchronised-lock cycles required before sequencing starts, range 1..255.
- `WATCHDOG_CYCLES`, default 100000: HOLD timeout before a PLL reset pulse; used only with the watchdog compiled in.

Ports:
- `clock`  in  1  fabric clock (post-BUFG PLL output).
- `rst`  in  1  synchronous, active-high reset.
- `pll_lock`  in  1  raw MMCM `LOCKED`, asynchronous to `clock`.
- `sw_reset_req`  in  1  single-cycle request to re-run the full sequence.
- `resetn`  out  CHANNELS  per-channel active-low reset; bit 0 is released first.
- `ready`  out  1  high while all channels are released.
- `lock_loss_count`  out  8  saturating count of lock losses seen in RELEASE or RUN.
- `pll_rst`  out  1  active-high MMCM reset pulse from the watchdog.

## Operation
- `pll_lock` passes through a two-flop synchroniser to produce `lock_sync`. There is no other use of `pll_lock`.
- States: HOLD, RELEASE, RUN.
- **HOLD**
  - All `resetn` are 0 and `ready` is 0.
  - The filter counter increments on each cycle with `lock_sync`=1 and clears to 0 on `lock_sync`=0.
  - On the LOCK_FILTER-th consecutive high cycle, go to RELEASE with stage index 0 and the delay counter at 0.
- **RELEASE**
  - The delay counter counts 0..STAGE_DELAY-1.
  - On terminal count, set `resetn[idx]`=1, increment `idx`, and clear the delay counter.
  - After setting `resetn[CHANNELS-1]`, go to RUN and set `ready`=1 in the same cycle.
  - Released bits stay 1 until the block returns to HOLD.
- **RUN**: all `resetn` are 1 and `ready` is 1.
- **Abort to HOLD.** From RELEASE or RUN, `lock_sync`=0 or `sw_reset_req`=1 causes:
  - next cycle, all `resetn`=0, `ready`=0, and the filter and delay counters cleared;
  - `lock_loss_count` increments, saturating at 255, only when `lock_sync`=0 caused the abort.
- `sw_reset_req` in HOLD clears the filter counter, which restarts the lock qualification.
- When `sw_reset_req` and lock loss coincide, the block makes a single transition to HOLD and the counter increments once.
- Counter widths are `$clog2` of the respective limit plus 1. No wrap-around is permitted.

## Timing
- Reset values (while `rst`=1):
  - state is HOLD;
  - `resetn`=0 on all bits;
  - `ready`=0;
  - `lock_loss_count`=0;
  - `pll_rst`=0;
  - synchroniser flops are 0.
- `rst` mid-sequence behaves identically to reset, and `lock_loss_count` is cleared.
- From the first cycle `pll_lock` is sampled high to entry into RELEASE: 2 + LOCK_FILTER cycles.
- `resetn[k]` rises (k+1)·STAGE_DELAY cycles after RELEASE entry. `ready` rises together with `resetn[CHANNELS-1]`.
- Abort latency: `resetn` falls 3 cycles after `pll_lock` falls (2 synchroniser cycles plus 1 register). It falls 1 cycle after `sw_reset_req`.
- A `lock_sync` glitch shorter than LOCK_FILTER cycles in HOLD never starts a sequence.
- All outputs are registered.

## Configuration
- `RESET_SEQ_WATCHDOG_EN` defined:
  - A HOLD timer counts cycles spent in HOLD and clears on leaving HOLD.
  - When the timer reaches WATCHDOG_CYCLES-1, `pll_rst` is driven high for exactly 4 cycles and the timer restarts from 0.
  - `sw_reset_req` clears the timer.
- `RESET_SEQ_WATCHDOG_EN` undefined: `pll_rst` is constant 0 and no timer logic is instantiated.

## Test plan
Parameters for all scenarios: CHANNELS=4, STAGE_DELAY=16, LOCK_FILTER=8.
- **Cold start.** Hold `rst` for 5 cycles, then raise `pll_lock` and keep it high. Required:
  - `resetn`=4'b0000 until cycle 26 after the first high sample;
  - `resetn[0]` rises at 26, `[1]` at 42, `[2]` at 58, `[3]` and `ready` at 74;
  - `lock_loss_count`=0.
- **Glitch rejection.** In HOLD, pulse `pll_lock` high for 5 cycles, low for 1 cycle, then high permanently. Required:
  - no release occurs before 2+8 cycles after the final rise;
  - `resetn[0]` rises 26 cycles after that rise.
- **Lock loss in RUN.** Drop `pll_lock` for 1 cycle. Required:
  - 3 cycles later, all `resetn`=0 and `ready`=0;
  - `lock_loss_count`=1;
  - the full sequence replays with the same spacing.
- **Abort mid-RELEASE.** Assert `sw_reset_req` while `resetn`=4'b0011. Required:
  - next cycle, `resetn`=4'b0000;
  - `lock_loss_count` unchanged;
  - `resetn[0]` rises again 8+16 cycles later.
- **Saturation.** Cause 260 lock losses. Required: `lock_loss_count`=255 and it does not wrap.
- **Watchdog** (macro defined, WATCHDOG_CYCLES=50). Keep `pll_lock` low. Required: `pll_rst` is high for 4 cycles starting at cycle 49 of HOLD, and every 50 cycles after that. With the macro undefined, `pll_rst` stays 0.
